exchange_buffer: RTL
====================

EXCHANGE_BUFFER -- requirements
Module: exchange_buffer

Interface
REQ-001 Parameter WIDTH, default 32: bits per replica data word.
REQ-002 Parameter DEPTH, default 32: words per frame; SHALL be ≥2.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles to wait for write completion after the last read.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd  in  2  exchange_command_t: NOP=0, PREV=1, FOLW=2, SELF=3.
REQ-008 cmd_ready  out  1  block can accept a command.
REQ-009 prev_valid / prev_data  in  1 / WIDTH  word stream from the previous replica.
REQ-010 folw_valid / folw_data  in  1 / WIDTH  word stream from the following replica.
REQ-011 out_valid / out_data / out_last  out  1 / WIDTH / 1  outgoing frame stream; out_last marks the final word.
REQ-012 done  out  1  one-cycle pulse at frame completion.
REQ-013 bank  out  1  current read bank.
REQ-014 err  out  1  sticky protocol error.

Function
REQ-015 State machine states: IDLE, RUN, WAIT; cmd_ready SHALL be 1 only in IDLE.
REQ-016 Command acceptance (cmd_valid & cmd_ready at cycle T) SHALL latch cmd, clear rcount and wcount, and enter RUN.
REQ-017 RUN reads: bank[bank][rcount] for rcount = 0..DEPTH-1, one word per cycle, with a registered read address.
REQ-018 out_valid SHALL be high exactly in cycles T+2..T+DEPTH+1; out_data is the corresponding word; out_last is high only at T+DEPTH+1.
REQ-019 Write source by latched cmd: PREV uses prev_*, FOLW uses folw_*, SELF uses own out_valid/out_data, NOP writes nothing.
REQ-020 Each source-valid cycle SHALL write its word to bank[~bank][wcount] and increment wcount; writes beyond DEPTH words in one frame SHALL be dropped and set err.
REQ-021 After the last read issue, the FSM SHALL go to WAIT unless the write frame is already complete.
REQ-022 The frame completes when the final read has been issued and (cmd==NOP or wcount==DEPTH). On completion, done pulses, the FSM returns to IDLE, and bank toggles (except for NOP, which never toggles).
REQ-023 If WAIT lasts TIMEOUT cycles without write completion, the FSM SHALL return to IDLE with no bank toggle, set err, and leave done low.
REQ-024 Source valid while in IDLE SHALL be ignored and set err.
REQ-025 A write and a read of the same address in one cycle are impossible (different banks); a same-cycle completion and a new cmd_valid are accepted no earlier than the next cycle.
REQ-026 The rcount/wcount width is $clog2(DEPTH+1); the wrap value DEPTH is compared exactly, with no modular wrap.

Reset
REQ-027 Reset asserted SHALL force IDLE, bank=0, rcount=wcount=0, out_valid=0, out_last=0, out_data=0, done=0, err=0, cmd_ready=1; RAM contents are undefined.
REQ-028 Reset mid-frame SHALL abort immediately with no partial bank toggle; err clears only on reset.

Structure
REQ-029 exchange_command_t and the default WIDTH/DEPTH constants SHALL reside in replica_pkg.
REQ-030 The two-bank 1R1W storage SHALL be sub-module exchange_bank_ram (parameters WIDTH, DEPTH; registered read).

Verification
REQ-031 DEPTH=4, bank 0 preloaded 10,11,12,13, cmd=PREV accepted at T, prev words 20..23 at T+3..T+6 -> out 10..13 at T+2..T+5, out_last at T+5, done at T+6, bank=1; next NOP reads 20..23.
REQ-032 DEPTH=4, cmd=SELF -> out 10..13 written back to bank 1; after done, bank=1 and a NOP frame outputs 10,11,12,13.
REQ-033 cmd=NOP -> four output words, done at T+5, bank unchanged, no writes.
REQ-034 cmd=FOLW with only 3 folw words, TIMEOUT=8 -> no done, err=1 eight cycles after WAIT entry, bank unchanged, cmd_ready=1.
REQ-035 prev_valid pulsed in IDLE -> err=1 and RAM unchanged; then reset low for 1 cycle mid-RUN -> all outputs at reset values, err=0.
REQ-036 cmd_valid held high throughout RUN with cmd=PREV -> only one acceptance per frame; the second command is accepted in the cycle after done.

Source files
------------

// File: rtl/replica_pkg.sv
// replica_pkg: exchange command encoding, FSM states and default sizes shared by the exchange buffer
package replica_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_DEPTH   = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PREV = 2'd1,
        CMD_FOLW = 2'd2,
        CMD_SELF = 2'd3
    } exchange_command_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } exchange_state_t;

endpackage

// File: rtl/exchange_bank_ram.sv
// exchange_bank_ram: two-bank storage, one write port and one registered read port
module exchange_bank_ram
    import replica_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     wbank,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic                     rbank,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [2][DEPTH];

    // write port and registered read port; the two banks never collide within a frame
    always_ff @(posedge clk) begin
        if (we) mem[wbank][waddr] <= wdata;
        if (re) rdata <= mem[rbank][raddr];
    end

endmodule

// File: rtl/exchange_buffer.sv
// exchange_buffer: streams one frame out of the read bank while filling the other bank from a chosen replica
module exchange_buffer
    import replica_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             folw_valid,
    input  logic [WIDTH-1:0] folw_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             bank,
    output logic             err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    exchange_state_t   state;
    exchange_command_t cmd_q;
    logic [CW-1:0]     rcount, wcount;
    logic [TW-1:0]     tcount;
    logic [WIDTH-1:0]  rdata, src_data;
    logic              src_valid, rd_issue, rd_done, wr_en, complete;

    // write source selection, read issue and frame completion (the final write counts in its own cycle)
    always_comb begin
        src_valid = cmd_q == CMD_PREV ? prev_valid :
                    cmd_q == CMD_FOLW ? folw_valid :
                    cmd_q == CMD_SELF ? out_valid  : 1'b0;
        src_data  = cmd_q == CMD_PREV ? prev_data :
                    cmd_q == CMD_FOLW ? folw_data : out_data;
        rd_issue  = state == ST_RUN && rcount != FULL;
        rd_done   = state == ST_WAIT || (state == ST_RUN && rcount == FULL);
        wr_en     = state != ST_IDLE && src_valid && wcount != FULL;
        complete  = rd_done && (cmd_q == CMD_NOP || wcount == FULL || (wr_en && wcount == LAST));
    end

    assign cmd_ready = state == ST_IDLE;
    assign done      = complete;
    assign out_data  = out_valid ? rdata : '0;

    exchange_bank_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .wbank(~bank),
        .waddr(wcount[AW-1:0]),
        .wdata(src_data),
        .re   (rd_issue),
        .rbank(bank),
        .raddr(rcount[AW-1:0]),
        .rdata(rdata)
    );

    // frame sequencing: counters, output strobes, bank flip on completion, sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_NOP;
            rcount    <= '0;
            wcount    <= '0;
            tcount    <= '0;
            bank      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_issue;
            out_last  <= rd_issue && rcount == LAST;
            if (rd_issue) rcount <= rcount + 1'b1;
            if (wr_en) wcount <= wcount + 1'b1;
            if ((state != ST_IDLE && src_valid && wcount == FULL) ||
                (state == ST_IDLE && (prev_valid || folw_valid))) err <= 1'b1;
            if (complete && cmd_q != CMD_NOP) bank <= ~bank;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state  <= ST_RUN;
                        cmd_q  <= exchange_command_t'(cmd);
                        rcount <= '0;
                        wcount <= '0;
                    end
                end
                ST_RUN: begin
                    tcount <= '0;
                    if (rd_done) state <= complete ? ST_IDLE : ST_WAIT;
                end
                default: begin
                    tcount <= tcount + 1'b1;
                    if (complete) state <= ST_IDLE;
                    else if (tcount == TLAST) begin
                        state <= ST_IDLE;
                        err   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
